// File: rtl/shift_acc.sv
// Bit-serial shift-accumulator: folds per-bit partial sums into a signed
// ACC_W result per lane, with a one-deep output holding register.

module shift_acc_lane #(
  parameter int PSUM_W = 10,
  parameter int ACC_W  = PSUM_W + 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              add,
  input  logic              sub,
  input  logic              clear,
  input  logic [5:0]        sel,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  fin
);
  logic signed [ACC_W-1:0] acc, ext, term;

  assign ext  = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
  assign term = ext <<< sel;
  // The top bit of a two's-complement operand carries negative weight.
  assign fin  = sub ? acc - term : acc + term;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      acc <= '0;
    else if (clear) acc <= '0;
    else if (load)  acc <= ext;
    else if (add)   acc <= fin;
  end
endmodule

module shift_acc #(
  parameter  int LANES  = 4,
  parameter  int PSUM_W = 10,
  localparam int ACC_W  = PSUM_W + 24
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [5:0]              sel,
  input  logic                    inwidth,
  input  logic                    sgn,
  input  logic [LANES*PSUM_W-1:0] psum,
  input  logic                    psum_vld,
  output logic [LANES*ACC_W-1:0]  res,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic                    err,
  output logic                    ovf,
  input  logic                    clr_err,
  output logic                    busy
);
  typedef enum logic {IDLE, ACC} state_t;

  state_t state, state_nxt;
  logic [5:0] expct, last_idx;
  logic       n24, sgn_l;
  logic       load, add, last, seq_err, clear, sub, drop;
  logic [LANES-1:0][ACC_W-1:0] fin, res_q;

  assign last_idx = n24 ? 6'd23 : 6'd11;
  assign busy     = (state == ACC);
  assign clear    = seq_err && (state == ACC);
  assign sub      = last && sgn_l;
  assign drop     = last && res_vld && !res_rdy;
  assign res      = res_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Since expct never exceeds N-1 in ACC, any sel >= N is a mismatch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    add       = 1'b0;
    last      = 1'b0;
    seq_err   = 1'b0;
    if (psum_vld) begin
      case (state)
        IDLE: begin
          if (sel == 6'd0) begin
            load      = 1'b1;
            state_nxt = ACC;
          end else begin
            seq_err = 1'b1;
          end
        end
        ACC: begin
          if (sel == expct) begin
            add = 1'b1;
            if (sel == last_idx) begin
              last      = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            seq_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      expct <= '0;
      n24   <= 1'b0;
      sgn_l <= 1'b0;
    end else if (load) begin
      expct <= 6'd1;
      n24   <= inwidth;
      sgn_l <= sgn;
    end else if (add) begin
      expct <= expct + 6'd1;
    end
  end

  // A completion that meets a pending, unaccepted result is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q   <= '0;
      res_vld <= 1'b0;
    end else if (last && !drop) begin
      res_q   <= fin;
      res_vld <= 1'b1;
    end else if (res_vld && res_rdy) begin
      res_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      err <= seq_err || (err && !clr_err);
      ovf <= drop    || (ovf && !clr_err);
    end
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      shift_acc_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load),
        .add   (add),
        .sub   (sub),
        .clear (clear),
        .sel   (sel),
        .psum  (psum[k*PSUM_W +: PSUM_W]),
        .fin   (fin[k])
      );
    end
  endgenerate
endmodule
